// File: rtl/radix4_seq_accum.sv
// Radix-4 sequential multiplier controller: issues four 2-bit B digits to an external
// 8x2 partial-product stage and shift-accumulates the returned products into a 16-bit result.
module radix4_seq_accum #(
  parameter int PP_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        ready_o,
  output logic [7:0]  pp_a_o,
  output logic [1:0]  pp_b_o,
  output logic        pp_valid_o,
  input  logic [9:0]  pp_i,
  output logic        valid_o,
  output logic [15:0] product_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  b_lat;
  logic [2:0]  issue_cnt;
  logic [1:0]  acc_cnt;
  logic [15:0] acc;
  logic [15:0] pp_ext;
  logic [15:0] pp_shift;
  logic [15:0] acc_sum;
  logic        pp_qual;
  logic        acc_en;

  // Delayed copy of pp_valid_o marks the cycle the matching pp_i is present.
  generate
    if (PP_LAT == 0) begin : g_nolat
      assign pp_qual = pp_valid_o;
    end else begin : g_lat
      logic [PP_LAT-1:0] vld_sr;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_sr <= '0;
        else         vld_sr <= (vld_sr << 1) | PP_LAT'(pp_valid_o);
      end
      assign pp_qual = vld_sr[PP_LAT-1];
    end
  endgenerate

  assign acc_en   = pp_qual && (state == RUN);
  assign pp_ext   = {{6{pp_i[9]}}, pp_i};
  assign pp_shift = pp_ext << {acc_cnt, 1'b0};
  assign acc_sum  = acc + pp_shift;
  assign ready_o  = (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = RUN;
      RUN:     if (acc_en && acc_cnt == 2'd3) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_lat      <= '0;
      issue_cnt  <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
      pp_a_o     <= '0;
      pp_b_o     <= '0;
      pp_valid_o <= 1'b0;
      valid_o    <= 1'b0;
      product_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pp_valid_o <= 1'b0;
          if (valid_i) begin
            // Digit 0 goes out straight from the inputs so issue starts the cycle after accept.
            b_lat      <= b_i;
            acc        <= '0;
            acc_cnt    <= '0;
            issue_cnt  <= 3'd1;
            pp_a_o     <= a_i;
            pp_b_o     <= b_i[1:0];
            pp_valid_o <= 1'b1;
          end
        end
        RUN: begin
          if (issue_cnt != 3'd4) begin
            pp_b_o     <= b_lat[{issue_cnt[1:0], 1'b0} +: 2];
            pp_valid_o <= 1'b1;
            issue_cnt  <= issue_cnt + 3'd1;
          end else begin
            pp_valid_o <= 1'b0;
          end
          if (acc_en) begin
            acc     <= acc_sum;
            acc_cnt <= acc_cnt + 2'd1;
            if (acc_cnt == 2'd3) begin
              product_o <= acc_sum;
              valid_o   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ready_i) valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_seq_accum.sv
// Bench for radix4_seq_accum: three instances (PP_LAT 0, 1, 3) share operand stimulus,
// each fed by its own partial-product stage model.
module tb_radix4_seq_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid;
  logic       ready;
  logic [7:0] a;
  logic [7:0] b;

  logic        r_o  [3];
  logic [7:0]  ppa  [3];
  logic [1:0]  ppb  [3];
  logic        ppv  [3];
  logic        vo   [3];
  logic [15:0] prod [3];

  logic [9:0] pi0, pi1, pi3;
  logic [9:0] p1, s0, s1, s2;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [9:0] pp_f(input logic [7:0] av, input logic [1:0] d);
    logic signed [9:0] ae, be;
    ae = {{2{av[7]}}, av};
    be = {8'b0, d};
    return ae * be;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  assign pi0 = pp_f(ppa[0], ppb[0]);
  assign pi1 = p1;
  assign pi3 = s2;
  always @(posedge clk) begin
    p1 <= pp_f(ppa[1], ppb[1]);
    s0 <= pp_f(ppa[2], ppb[2]);
    s1 <= s0;
    s2 <= s1;
  end

  radix4_seq_accum #(.PP_LAT(0)) u_lat0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .a_i(a), .b_i(b),
    .ready_o(r_o[0]), .pp_a_o(ppa[0]), .pp_b_o(ppb[0]), .pp_valid_o(ppv[0]),
    .pp_i(pi0), .valid_o(vo[0]), .product_o(prod[0]), .ready_i(ready));

  radix4_seq_accum #(.PP_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .a_i(a), .b_i(b),
    .ready_o(r_o[1]), .pp_a_o(ppa[1]), .pp_b_o(ppb[1]), .pp_valid_o(ppv[1]),
    .pp_i(pi1), .valid_o(vo[1]), .product_o(prod[1]), .ready_i(ready));

  radix4_seq_accum #(.PP_LAT(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .a_i(a), .b_i(b),
    .ready_o(r_o[2]), .pp_a_o(ppa[2]), .pp_b_o(ppb[2]), .pp_valid_o(ppv[2]),
    .pp_i(pi3), .valid_o(vo[2]), .product_o(prod[2]), .ready_i(ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_rdy%0d", tag, i),  32'(r_o[i]), 32'd1);
      check($sformatf("%s_vo%0d", tag, i),   32'(vo[i]),  32'd0);
      check($sformatf("%s_ppv%0d", tag, i),  32'(ppv[i]), 32'd0);
      check($sformatf("%s_ppa%0d", tag, i),  32'(ppa[i]), 32'd0);
      check($sformatf("%s_ppb%0d", tag, i),  32'(ppb[i]), 32'd0);
      check($sformatf("%s_prod%0d", tag, i), 32'(prod[i]), 32'd0);
    end
  endtask

  // One product with ready held high; latency counted in edges after the accept edge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp);
    int          lat [3];
    logic [15:0] got [3];
    logic [1:0]  dg  [4];
    logic        dv  [4];
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      got[i] = '0;
    end
    @(negedge clk);
    a = av; b = bv; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check({tag, "_rdy_drop"}, 32'(r_o[1]), 32'd0);
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        dg[c] = ppb[1];
        dv[c] = ppv[1];
      end
      for (int i = 0; i < 3; i++)
        if (vo[i] && lat[i] == 0) begin
          lat[i] = c;
          got[i] = prod[i];
        end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_dig%0d", tag, k), 32'(dg[k]), 32'(bv[2*k +: 2]));
      check($sformatf("%s_dvld%0d", tag, k), 32'(dv[k]), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lat_L%0d", tag, lat_of(i)), 32'(lat[i]), 32'(4 + lat_of(i)));
      check($sformatf("%s_prod_L%0d", tag, lat_of(i)), 32'(got[i]), 32'(exp));
      check($sformatf("%s_idle_L%0d", tag, lat_of(i)), 32'(r_o[i]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst_n = 1'b1;

    run_op("a5b3",   8'd5,   8'd3,   16'h000F);
    run_op("min",    8'h80,  8'hFF,  16'h8080);
    run_op("max",    8'h7F,  8'hFF,  16'h7E81);
    run_op("m1b0",   8'hFF,  8'h00,  16'h0000);
    run_op("m1b1",   8'hFF,  8'h01,  16'hFFFF);

    // Backpressure: products wait in DONE, a valid pulse there must not queue.
    @(negedge clk);
    ready = 1'b0; a = 8'd3; b = 8'd10; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid = (c == 1);
      a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      valid = 1'b0;
      check($sformatf("bp_vo_%0d", c),    32'(vo[1]),   32'd1);
      check($sformatf("bp_prod_%0d", c),  32'(prod[1]), 32'h001E);
      check($sformatf("bp_rdy_%0d", c),   32'(r_o[1]),  32'd0);
      check($sformatf("bp_prod3_%0d", c), 32'(prod[2]), 32'h001E);
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vo",   32'(vo[1]),   32'd0);
    check("bp_rel_rdy",  32'(r_o[1]),  32'd1);
    check("bp_rel_prod", 32'(prod[1]), 32'h001E);
    repeat (3) @(posedge clk);
    #1;
    check("bp_noqueue_rdy", 32'(r_o[1]), 32'd1);
    check("bp_noqueue_ppv", 32'(ppv[1]), 32'd0);

    // Reset mid-RUN after two digits have been issued.
    @(negedge clk);
    a = 8'h64; b = 8'hFF; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset("midrun");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op("m7b200", 8'hF9, 8'hC8, 16'hFA88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
